// File: rtl/memory_arbiter.sv
// Two-port arbiter in front of a single memory_bus: each access holds the bus
// for ACCESS_CYCLES cycles, then pulses a one-cycle ack to the winning requester.
module memory_arbiter #(
    parameter int ACCESS_CYCLES  = 2,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        a_request,
    input  logic        a_write_enable,
    input  logic [15:0] a_address,
    input  logic [15:0] a_data_in,
    output logic [15:0] a_data_out,
    output logic        a_ack,

    input  logic        b_request,
    input  logic        b_write_enable,
    input  logic [15:0] b_address,
    input  logic [15:0] b_data_in,
    output logic [15:0] b_data_out,
    output logic        b_ack,

    output logic [15:0] mem_address,
    output logic [15:0] mem_data_out,
    input  logic [15:0] mem_data_in,
    output logic        mem_bus_enable,
    output logic        mem_write_enable,
    output logic        busy
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Port encoding used by grant_reg / last_grant_reg: 0 = A, 1 = B.
    state_t        state_reg;
    logic [CW-1:0] counter_reg;
    logic          last_grant_reg;
    logic          grant_reg;
    logic          write_enable_reg;
    logic [15:0]   address_reg;
    logic [15:0]   data_reg;

    logic          grant_next;
    logic          access_last;

    always_comb begin
        grant_next = 1'b0;
        if (!a_request) begin
            grant_next = 1'b1;
        end else if (b_request && (FIXED_PRIORITY == 0) && (last_grant_reg == 1'b0)) begin
            grant_next = 1'b1;
        end
    end

    assign access_last = (state_reg == ACCESS) && (counter_reg == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            counter_reg      <= '0;
            last_grant_reg   <= 1'b1;
            grant_reg        <= 1'b0;
            write_enable_reg <= 1'b0;
            address_reg      <= '0;
            data_reg         <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (a_request || b_request) begin
                        address_reg      <= grant_next ? b_address      : a_address;
                        data_reg         <= grant_next ? b_data_in      : a_data_in;
                        write_enable_reg <= grant_next ? b_write_enable : a_write_enable;
                        grant_reg        <= grant_next;
                        last_grant_reg   <= grant_next;
                        counter_reg      <= '0;
                        state_reg        <= ACCESS;
                    end
                end
                ACCESS: begin
                    counter_reg <= counter_reg + 1'b1;
                    if (access_last) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Per-requester completion: ack pulse and read-data capture.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_port
        localparam logic PORT_ID = 1'(gi);
        logic        ack_reg;
        logic [15:0] data_out_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                ack_reg      <= 1'b0;
                data_out_reg <= '0;
            end else begin
                ack_reg <= access_last && (grant_reg == PORT_ID);
                if (access_last && (grant_reg == PORT_ID) && !write_enable_reg) begin
                    data_out_reg <= mem_data_in;
                end
            end
        end
    end

    assign a_ack      = gen_port[0].ack_reg;
    assign a_data_out = gen_port[0].data_out_reg;
    assign b_ack      = gen_port[1].ack_reg;
    assign b_data_out = gen_port[1].data_out_reg;

    // Write strobe only in the first bus cycle so each write commits once.
    assign mem_bus_enable   = (state_reg == ACCESS);
    assign mem_write_enable = (state_reg == ACCESS) && (counter_reg == '0) && write_enable_reg;
    assign mem_address      = address_reg;
    assign mem_data_out     = data_reg;
    assign busy             = (state_reg != IDLE);

endmodule
